// File: rtl/ram_responder.sv
// Shared-memory responder: round-robin arbitration of two cache ports onto one
// word-addressed memory, fixed-latency beats, and atomic-write forwarding.
module ram_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] p0_ram_addr,
  input  logic [DATA_W-1:0] p0_ram_data_w,
  input  logic              p0_ram_read,
  input  logic              p0_ram_write,
  input  logic              p0_atomic_in,
  output logic              p0_ram_wait,
  output logic [DATA_W-1:0] p0_ram_data_r,
  output logic              p0_arbiter_permit,
  output logic              p0_atomic_out,
  output logic [ADDR_W-1:0] p0_snoop_addr,
  input  logic [ADDR_W-1:0] p1_ram_addr,
  input  logic [DATA_W-1:0] p1_ram_data_w,
  input  logic              p1_ram_read,
  input  logic              p1_ram_write,
  input  logic              p1_atomic_in,
  output logic              p1_ram_wait,
  output logic [DATA_W-1:0] p1_ram_data_r,
  output logic              p1_arbiter_permit,
  output logic              p1_atomic_out,
  output logic [ADDR_W-1:0] p1_snoop_addr
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              ptr_reg, ptr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              write_reg;
  logic              atomic_reg;
  logic              load;
  logic              sel;

  logic [1:0]        req;
  logic [1:0]        wr_in;
  logic [1:0]        atomic_in;
  logic [ADDR_W-1:0] addr_in [2];
  logic [DATA_W-1:0] data_in [2];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;
  logic [MEM_ADDR_W-1:0] mem_idx;
  logic              mem_we;

  logic              wait_arr   [2];
  logic              permit_arr [2];
  logic              atomic_arr [2];
  logic [ADDR_W-1:0] snoop_arr  [2];
  logic [DATA_W-1:0] data_r_arr [2];

  // Write beats win over reads when a cache asserts both.
  assign req       = {p1_ram_read | p1_ram_write, p0_ram_read | p0_ram_write};
  assign wr_in     = {p1_ram_write, p0_ram_write};
  assign atomic_in = {p1_atomic_in, p0_atomic_in};
  assign addr_in[0] = p0_ram_addr;
  assign addr_in[1] = p1_ram_addr;
  assign data_in[0] = p0_ram_data_w;
  assign data_in[1] = p1_ram_data_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      ptr_reg    <= 1'b0;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      write_reg  <= 1'b0;
      atomic_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        addr_reg   <= addr_in[sel];
        data_reg   <= data_in[sel];
        write_reg  <= wr_in[sel];
        atomic_reg <= atomic_in[sel];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    sel        = owner_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = ACCESS;
          sel        = (req == 2'b11) ? ptr_reg : req[1];
          owner_next = sel;
          load       = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_reg <= CNT_W'(1)) state_next = RESP;
        else                      cnt_next   = cnt_reg - CNT_W'(1);
      end
      RESP: begin
        // A held request continues the burst without re-arbitration.
        if (req[owner_reg]) begin
          state_next = ACCESS;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
          ptr_next   = ~owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) cnt_next = CNT_W'(LATENCY);
  end

  assign mem_idx = addr_reg[MEM_ADDR_W-1:0];
  assign mem_we  = (state_reg == RESP) && write_reg;

  // Registered read tracks the latched index through ACCESS, so RESP sees
  // any write committed by the previous beat.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= data_reg;
    rd_data_reg <= mem[mem_idx];
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic              is_owner;
      logic              resp_own;
      logic              fwd;
      logic [DATA_W-1:0] hold_reg;

      assign is_owner = (owner_reg == 1'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                     hold_reg <= '0;
        else if ((state_reg == RESP) && is_owner && !write_reg) hold_reg <= rd_data_reg;
      end

      always_comb begin
        resp_own = (state_reg == RESP) && is_owner;
        fwd      = (state_reg == RESP) && write_reg && atomic_reg && !is_owner;
        wait_arr[gi]   = !resp_own;
        permit_arr[gi] = (state_reg != IDLE) && is_owner;
        atomic_arr[gi] = fwd;
        snoop_arr[gi]  = fwd ? addr_reg : '0;
        if (fwd)                       data_r_arr[gi] = data_reg;
        else if (resp_own && !write_reg) data_r_arr[gi] = rd_data_reg;
        else                           data_r_arr[gi] = hold_reg;
      end
    end
  endgenerate

  assign p0_ram_wait       = wait_arr[0];
  assign p0_ram_data_r     = data_r_arr[0];
  assign p0_arbiter_permit = permit_arr[0];
  assign p0_atomic_out     = atomic_arr[0];
  assign p0_snoop_addr     = snoop_arr[0];
  assign p1_ram_wait       = wait_arr[1];
  assign p1_ram_data_r     = data_r_arr[1];
  assign p1_arbiter_permit = permit_arr[1];
  assign p1_atomic_out     = atomic_arr[1];
  assign p1_snoop_addr     = snoop_arr[1];

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder with LATENCY=2.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] p0_ram_addr, p1_ram_addr;
  logic [31:0] p0_ram_data_w, p1_ram_data_w;
  logic        p0_ram_read, p0_ram_write, p0_atomic_in;
  logic        p1_ram_read, p1_ram_write, p1_atomic_in;
  logic        p0_ram_wait, p1_ram_wait;
  logic [31:0] p0_ram_data_r, p1_ram_data_r;
  logic        p0_arbiter_permit, p1_arbiter_permit;
  logic        p0_atomic_out, p1_atomic_out;
  logic [31:0] p0_snoop_addr, p1_snoop_addr;

  int errors = 0;
  int checks = 0;

  ram_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_ram_addr(p0_ram_addr), .p0_ram_data_w(p0_ram_data_w),
    .p0_ram_read(p0_ram_read), .p0_ram_write(p0_ram_write), .p0_atomic_in(p0_atomic_in),
    .p0_ram_wait(p0_ram_wait), .p0_ram_data_r(p0_ram_data_r),
    .p0_arbiter_permit(p0_arbiter_permit), .p0_atomic_out(p0_atomic_out),
    .p0_snoop_addr(p0_snoop_addr),
    .p1_ram_addr(p1_ram_addr), .p1_ram_data_w(p1_ram_data_w),
    .p1_ram_read(p1_ram_read), .p1_ram_write(p1_ram_write), .p1_atomic_in(p1_atomic_in),
    .p1_ram_wait(p1_ram_wait), .p1_ram_data_r(p1_ram_data_r),
    .p1_arbiter_permit(p1_arbiter_permit), .p1_atomic_out(p1_atomic_out),
    .p1_snoop_addr(p1_snoop_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data, input logic atomic);
    if (port == 0) begin
      p0_ram_read = rd; p0_ram_write = wr; p0_ram_addr = addr;
      p0_ram_data_w = data; p0_atomic_in = atomic;
    end else begin
      p1_ram_read = rd; p1_ram_write = wr; p1_ram_addr = addr;
      p1_ram_data_w = data; p1_atomic_in = atomic;
    end
  endtask

  // Drives one beat, returns the cycle (after the request edge) of the wait-low
  // pulse and the data seen then; drops the request and steps into IDLE.
  task automatic run_beat(input int port, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data, input logic atomic,
                          output logic [31:0] rdata, output int lat);
    bit done = 0;
    set_req(port, rd, wr, addr, data, atomic);
    lat = -1;
    rdata = '0;
    for (int n = 1; n <= 10; n++) begin
      if (!done) begin
        tick();
        if ((port == 0 ? p0_ram_wait : p1_ram_wait) == 1'b0) begin
          lat = n;
          rdata = (port == 0) ? p0_ram_data_r : p1_ram_data_r;
          done = 1;
        end
      end
    end
    set_req(port, 1'b0, 1'b0, addr, data, 1'b0);
    tick();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    obs = {p0_ram_wait, p1_ram_wait, p0_arbiter_permit, p1_arbiter_permit,
           p0_atomic_out, p1_atomic_out, |p0_ram_data_r, |p1_ram_data_r,
           |p0_snoop_addr, |p1_snoop_addr};
    checks++;
    if (obs !== 10'b11_0000_0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 10'b11_0000_0000);
    end
    $display("reset: outputs=%b", obs);
  endtask

  task automatic test_single_write_read();
    logic [31:0] rd; int lat;
    run_beat(0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 1'b0, rd, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
    $display("write p0 addr=0x5 data=0xdeadbeef lat=%0d", lat);
    run_beat(0, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0, rd, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rd); end
    checks++;
    if (p0_ram_data_r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data_held: got %h expected deadbeef", p0_ram_data_r);
    end
    checks++;
    if (p0_arbiter_permit !== 1'b0) begin errors++; $display("FAIL permit_idle: got %b expected 0", p0_arbiter_permit); end
    $display("read p0 addr=0x5 data=%h lat=%0d", rd, lat);
  endtask

  // Writes then reads a 16-beat burst; the read checks data and 3-cycle spacing.
  task automatic test_burst();
    for (int pass = 0; pass < 2; pass++) begin
      int beats = 0; int gap = 0; int bad_gap = 0; int bad_data = 0;
      set_req(0, pass == 1, pass == 0, 32'h100, 32'h100, 1'b0);
      for (int c = 0; c < 80 && beats < 16; c++) begin
        tick();
        gap++;
        if (p0_ram_wait == 1'b0) begin
          if (gap != 3) bad_gap++;
          if (pass == 1 && p0_ram_data_r !== 32'h100 + 32'(beats)) bad_data++;
          if (pass == 1) $display("burst read beat=%0d data=%h gap=%0d", beats, p0_ram_data_r, gap);
          beats++;
          gap = 0;
          if (beats == 16) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
          else set_req(0, pass == 1, pass == 0, 32'h100 + 32'(beats), 32'h100 + 32'(beats), 1'b0);
        end
      end
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      checks++;
      if (beats !== 16) begin errors++; $display("FAIL burst_beats pass=%0d: got %0d expected 16", pass, beats); end
      checks++;
      if (bad_gap !== 0) begin errors++; $display("FAIL burst_spacing pass=%0d: got %0d bad gaps expected 0", pass, bad_gap); end
      if (pass == 1) begin
        checks++;
        if (bad_data !== 0) begin errors++; $display("FAIL burst_data: got %0d bad beats expected 0", bad_data); end
      end
    end
  endtask

  task automatic test_contention();
    int found = 0;
    apply_reset();
    set_req(0, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    tick();
    checks++;
    if ({p0_arbiter_permit, p1_arbiter_permit} !== 2'b10) begin
      errors++; $display("FAIL contention_first_grant: got %b expected 10", {p0_arbiter_permit, p1_arbiter_permit});
    end
    tick(); tick();
    checks++;
    if ({p0_ram_wait, p1_ram_wait, p0_ram_data_r} !== {2'b01, 32'hDEADBEEF}) begin
      errors++; $display("FAIL contention_p0_resp: got %b%b %h expected 01 deadbeef", p0_ram_wait, p1_ram_wait, p0_ram_data_r);
    end
    p0_ram_read = 1'b0;
    tick();
    checks++;
    if ({p0_arbiter_permit, p1_arbiter_permit} !== 2'b00) begin
      errors++; $display("FAIL contention_idle_gap: got %b expected 00", {p0_arbiter_permit, p1_arbiter_permit});
    end
    p0_ram_read = 1'b1;  // both request again; pointer now favours p1
    tick();
    checks++;
    if ({p0_arbiter_permit, p1_arbiter_permit} !== 2'b01) begin
      errors++; $display("FAIL contention_second_grant: got %b expected 01", {p0_arbiter_permit, p1_arbiter_permit});
    end
    $display("contention: p1 permit=%b after one idle cycle", p1_arbiter_permit);
    for (int c = 0; c < 6 && found == 0; c++) begin
      tick();
      if (p1_ram_wait == 1'b0) found = c + 2;
    end
    checks++;
    if (found !== 3 || p1_ram_data_r !== 32'h100) begin
      errors++; $display("FAIL contention_p1_resp: got lat=%0d data=%h expected lat=3 data=00000100", found, p1_ram_data_r);
    end
    p1_ram_read = 1'b0;
    tick(); tick();
    checks++;
    if ({p0_arbiter_permit, p1_arbiter_permit} !== 2'b10) begin
      errors++; $display("FAIL contention_third_grant: got %b expected 10", {p0_arbiter_permit, p1_arbiter_permit});
    end
    tick(); tick();
    p0_ram_read = 1'b0;
    tick();
  endtask

  task automatic test_atomic();
    int found = 0;
    set_req(1, 1'b0, 1'b1, 32'h2A, 32'h1234, 1'b1);
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (p1_ram_wait == 1'b0) found = 1;
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL atomic_resp_seen: got %0d expected 1", found); end
    checks++;
    if ({p0_atomic_out, p0_ram_wait, p1_atomic_out} !== 3'b110) begin
      errors++; $display("FAIL atomic_strobe: got %b expected 110", {p0_atomic_out, p0_ram_wait, p1_atomic_out});
    end
    checks++;
    if (p0_snoop_addr !== 32'h2A || p0_ram_data_r !== 32'h1234) begin
      errors++; $display("FAIL atomic_payload: got addr=%h data=%h expected 0000002a 00001234", p0_snoop_addr, p0_ram_data_r);
    end
    $display("atomic p1 addr=0x2a: p0 atomic_out=%b snoop=%h data=%h", p0_atomic_out, p0_snoop_addr, p0_ram_data_r);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++;
    if (p0_atomic_out !== 1'b0 || p0_ram_data_r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL atomic_one_cycle: got strobe=%b data=%h expected 0 deadbeef", p0_atomic_out, p0_ram_data_r);
    end
  endtask

  task automatic test_read_write_both();
    logic [31:0] rd; int lat;
    run_beat(0, 1'b1, 1'b1, 32'h33, 32'hCAFEF00D, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_no_read_data: got %h expected deadbeef", rd); end
    run_beat(0, 1'b1, 1'b0, 32'h33, 32'h0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_readback: got %h expected cafef00d", rd); end
    $display("read+write p0 addr=0x33 readback=%h", rd);
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat;
    run_beat(1, 1'b0, 1'b1, 32'h3FF, 32'hA5A5, 1'b0, rd, lat);
    run_beat(1, 1'b0, 1'b1, 32'h400, 32'h5A5A, 1'b0, rd, lat);
    run_beat(0, 1'b1, 1'b0, 32'h3FF, 32'h0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'hA5A5) begin errors++; $display("FAIL wrap_top: got %h expected 0000a5a5", rd); end
    run_beat(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h5A5A) begin errors++; $display("FAIL wrap_alias: got %h expected 00005a5a", rd); end
    $display("wrap: idx 0 via addr 0x400 = %h", rd);
  endtask

  task automatic test_reset_mid_beat();
    logic [31:0] rd; int lat;
    run_beat(0, 1'b0, 1'b1, 32'h7, 32'h55, 1'b0, rd, lat);
    set_req(0, 1'b0, 1'b1, 32'h7, 32'hAA, 1'b0);
    tick();
    checks++;
    if (p0_arbiter_permit !== 1'b1) begin errors++; $display("FAIL midbeat_permit: got %b expected 1", p0_arbiter_permit); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({p0_arbiter_permit, p0_ram_wait, p0_ram_data_r} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL midbeat_reset_outputs: got %b%b %h expected 01 00000000", p0_arbiter_permit, p0_ram_wait, p0_ram_data_r);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    run_beat(0, 1'b1, 1'b0, 32'h7, 32'h0, 1'b0, rd, lat);
    checks++;
    if (rd !== 32'h55) begin errors++; $display("FAIL midbeat_no_commit: got %h expected 00000055", rd); end
    $display("reset mid-beat: mem[7]=%h", rd);
  endtask

  initial begin
    reset_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_single_write_read();
    test_burst();
    test_contention();
    test_atomic();
    test_read_write_both();
    test_wrap();
    test_reset_mid_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Shared-memory responder for the cache RAM interface. It sits between two cache instances and a word-addressed memory array. It arbitrates the two caches round-robin, serves their read/write beats with a fixed, parameterised latency, and signals each completed beat by dropping `ram_wait` for one cycle. Atomic writes from one cache are forwarded as a one-cycle update beat to the other cache.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, cache-side address width
- `MEM_ADDR_W`, 10, memory index width (2^MEM_ADDR_W words, indexed by `addr[MEM_ADDR_W-1:0]`; upper bits ignored, aliasing allowed)
- `LATENCY`, 2, wait cycles per beat (≥1)

Ports, listed per port p∈{0,1} with prefix `p0_`/`p1_`:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `pX_ram_addr` in ADDR_W: beat address from cache X
- `pX_ram_data_w` in DATA_W: write data from cache X
- `pX_ram_read` in 1: read request, held for the whole burst
- `pX_ram_write` in 1: write request, held for the whole burst
- `pX_atomic_in` in 1: cache X marks the current write as atomic
- `pX_ram_wait` out 1: low for exactly one cycle per completed beat; otherwise high
- `pX_ram_data_r` out DATA_W: read data, or forwarded atomic data
- `pX_arbiter_permit` out 1: port X currently owns memory
- `pX_atomic_out` out 1: one-cycle atomic update strobe to cache X
- `pX_snoop_addr` out ADDR_W: address accompanying `pX_atomic_out`

## Operation
- Reset values:
  - all `ram_wait` = 1
  - all `ram_data_r`, `snoop_addr` = 0
  - all `arbiter_permit`, `atomic_out` = 0
  - FSM in IDLE; round-robin pointer favours port 0
  - Memory contents are not cleared.
- Request: port X requests when `pX_ram_read | pX_ram_write`. If both are asserted, the write takes precedence.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when any port requests.
    - If only one port requests, that port wins.
    - If both request, the pointer port wins.
    - The winner's `arbiter_permit` is asserted.
    - Address, data, kind and atomic flag are latched at ACCESS entry.
  - ACCESS: a counter counts `LATENCY` cycles. Input changes during ACCESS are ignored. The counter width is $clog2(LATENCY+1).
  - ACCESS → RESP when the counter expires. In the RESP cycle:
    - Owner's `ram_wait` = 0.
    - Read: `ram_data_r` = mem[latched index], held until the next RESP of that port.
    - Write: mem[latched index] ← latched data, committed at the end of the RESP cycle.
  - RESP → ACCESS if the owner's request is still asserted. The new beat's inputs are latched on this edge and ownership is kept (burst).
  - RESP → IDLE if the owner's request is deasserted. `arbiter_permit` drops, and the pointer moves to the other port.
- Atomic forward: in the RESP cycle of a write with latched atomic = 1, the other port gets the following for that same single cycle:
  - `atomic_out` = 1
  - `snoop_addr` = latched address
  - `ram_data_r` = latched data
  - The other port's `ram_wait` stays 1.
- Non-owner port: `ram_wait` = 1 and `arbiter_permit` = 0 at all times.
- Read-after-write to the same index by the next beat returns the new data (the write commits before the next ACCESS begins).
- Reset mid-operation: all outputs return to their reset values immediately.
  - A write whose RESP edge has not occurred is not committed.
  - Any pending grant is lost.

## Timing
- Request seen in IDLE at edge t → ACCESS and permit from t+1 → RESP (`ram_wait` low) in cycle t+1+LATENCY.
- Burst beat-to-beat period: LATENCY+1 cycles.
- Handover: owner deasserts its request during RESP → IDLE at the next edge. A waiting port is granted one cycle later. The IDLE cycle is mandatory.
- `atomic_out` pulse width is exactly one cycle, coincident with the owner's RESP.
- Wrap-around: address bits above `MEM_ADDR_W` are ignored. Index 2^MEM_ADDR_W−1 followed by 0 needs no special handling.
- Requests that arrive during another port's ACCESS/RESP wait without loss. The cache holds its request; the responder does not queue.

## Test plan
- Single write/read, LATENCY=2:
  - Stimulus: p0 writes 0xDEADBEEF to addr 0x5.
  - Required: `ram_wait` low in cycle t+3.
  - Stimulus: p0 then reads addr 0x5.
  - Required: `ram_data_r` = 0xDEADBEEF in its RESP cycle.
- 16-beat burst:
  - Stimulus: p0 holds `ram_read` for 16 beats at addresses 0x100..0x10F, with the memory preloaded with index values.
  - Required: 16 `ram_wait` low pulses, spaced 3 cycles apart, returning 0x100..0x10F (masked values).
- Contention:
  - Stimulus: p0 and p1 both request in the same cycle from reset.
  - Required: p0 is served first. After p0 drops its request, there is one IDLE cycle, then p1's `arbiter_permit` rises.
  - Stimulus: both request again.
  - Required: p1 wins.
- Atomic forward:
  - Stimulus: p1 writes 0x1234 to addr 0x2A with `atomic_in`=1.
  - Required: in the RESP cycle, `p0_atomic_out`=1, `p0_snoop_addr`=0x2A, `p0_ram_data_r`=0x1234 for one cycle; `p0_ram_wait` stays 1.
- Read+write asserted together:
  - Stimulus: p0 asserts `ram_read` and `ram_write` together.
  - Required: the write is performed; a subsequent read returns the written data.
- Reset mid-beat:
  - Stimulus: `reset_n` low during the ACCESS of a write of 0xAA to addr 7 (mem[7] was 0x55).
  - Required: all outputs are at reset values immediately; a subsequent read of addr 7 returns 0x55.
